// File: rtl/call_stack_ctrl.sv
// Call/return sequencer: issues register-bank push/pop strobes, tracks the frame pointer
// and keeps a LIFO of return addresses. Define CALL_STACK_GUARD_EN for sticky overflow/underflow flags.
module call_stack_ctrl #(
  parameter int PC_WIDTH = 5,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                call_req,
  input  logic [PC_WIDTH-1:0] call_pc,
  input  logic                ret_req,
  output logic                call_ack,
  output logic                ret_ack,
  output logic [PC_WIDTH-1:0] ret_pc,
  output logic                busy,
  output logic                stack_full,
  output logic                rf_stack_push,
  output logic                rf_stack_pop,
  output logic [PC_WIDTH-1:0] rf_stack_pointer,
  output logic                call_err,
  output logic                ret_err
);

  localparam int                  AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_WIDTH-1:0] DEPTH_P = PC_WIDTH'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_REJ_CALL,
    S_REJ_RET
  } state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] ptr;
  logic [PC_WIDTH-1:0] ret_addr_p0;
  logic [PC_WIDTH-1:0] ra_mem [DEPTH];
  logic [AW-1:0]       top_idx;
  logic                is_full;
  logic                is_empty;
  logic                accept_call;

  // Frame n lives in ra_mem[n-1]; during PUSH the pointer already holds the new frame number.
  assign top_idx     = AW'(ptr - 1'b1);
  assign is_full     = (ptr == DEPTH_P);
  assign is_empty    = (ptr == '0);
  assign accept_call = (state == S_IDLE) && call_req && !is_full;

  always_comb begin
    state_nxt     = state;
    rf_stack_push = 1'b0;
    rf_stack_pop  = 1'b0;
    call_ack      = 1'b0;
    ret_ack       = 1'b0;
    ret_pc        = '0;
    case (state)
      S_IDLE: begin
        if (call_req)     state_nxt = is_full  ? S_REJ_CALL : S_PUSH;
        else if (ret_req) state_nxt = is_empty ? S_REJ_RET  : S_POP;
      end
      S_PUSH: begin
        rf_stack_push = 1'b1;
        call_ack      = 1'b1;
        state_nxt     = S_IDLE;
      end
      S_POP: begin
        rf_stack_pop = 1'b1;
        ret_ack      = 1'b1;
        ret_pc       = ra_mem[top_idx];
        state_nxt    = S_IDLE;
      end
      S_REJ_CALL: begin
        call_ack  = 1'b1;
        state_nxt = S_IDLE;
      end
      S_REJ_RET: begin
        ret_ack   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM and frame pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (accept_call)         ptr <= ptr + 1'b1;
      else if (state == S_POP) ptr <= ptr - 1'b1;
    end
  end

  // Return-address datapath: capture in IDLE, commit to the LIFO in PUSH
  always_ff @(posedge clk) begin
    if (accept_call)          ret_addr_p0      <= call_pc + 1'b1;
    if (state == S_PUSH)      ra_mem[top_idx]  <= ret_addr_p0;
  end

`ifdef CALL_STACK_GUARD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      call_err <= 1'b0;
      ret_err  <= 1'b0;
    end else begin
      if (state == S_REJ_CALL) call_err <= 1'b1;
      if (state == S_REJ_RET)  ret_err  <= 1'b1;
    end
  end
`else
  assign call_err = 1'b0;
  assign ret_err  = 1'b0;
`endif

  assign busy             = (state != S_IDLE);
  assign stack_full       = is_full;
  assign rf_stack_pointer = ptr;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Self-checking bench for call_stack_ctrl: directed vector table, hand-written corner
// sequences, and randomized CALL/RET traffic against a queue-based reference model.
module tb_call_stack_ctrl;

  localparam int PW = 5;
  localparam int DP = 8;
`ifdef CALL_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          call_req = 1'b0;
  logic [PW-1:0] call_pc = '0;
  logic          ret_req = 1'b0;
  logic          call_ack, ret_ack, busy, stack_full;
  logic          rf_stack_push, rf_stack_pop, call_err, ret_err;
  logic [PW-1:0] ret_pc, rf_stack_pointer;

  call_stack_ctrl #(.PC_WIDTH(PW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .call_req(call_req), .call_pc(call_pc), .ret_req(ret_req),
    .call_ack(call_ack), .ret_ack(ret_ack), .ret_pc(ret_pc), .busy(busy),
    .stack_full(stack_full), .rf_stack_push(rf_stack_push), .rf_stack_pop(rf_stack_pop),
    .rf_stack_pointer(rf_stack_pointer), .call_err(call_err), .ret_err(ret_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          c;
    bit          r;
    logic [4:0]  pc;
    bit          push, pop, cack, rack;
    bit          chk_rpc;
    logic [4:0]  rpc;
    logic [4:0]  ptr, ptr_after;
    bit          full_after;
  } vec_t;

  vec_t tbl[$];

  // Values sampled one edge after the request is seen, and one edge after that.
  logic          s_push, s_pop, s_cack, s_rack, s_busy, s_busy_a, s_full_a, s_ack_a;
  logic [PW-1:0] s_rpc, s_ptr, s_ptr_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input bit c, input bit r, input logic [PW-1:0] pc);
    @(negedge clk);
    call_req = c; ret_req = r; call_pc = pc;
    @(posedge clk); #1;
    s_push = rf_stack_push; s_pop = rf_stack_pop; s_cack = call_ack; s_rack = ret_ack;
    s_rpc = ret_pc; s_ptr = rf_stack_pointer; s_busy = busy;
    call_req = 1'b0; ret_req = 1'b0;
    @(posedge clk); #1;
    s_ptr_a = rf_stack_pointer; s_busy_a = busy; s_full_a = stack_full;
    s_ack_a = call_ack | ret_ack;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  function automatic vec_t mk(bit c, bit r, logic [4:0] pc, bit push, bit pop, bit cack,
                              bit rack, bit chk_rpc, logic [4:0] rpc, logic [4:0] ptr,
                              logic [4:0] ptr_after, bit full_after);
    vec_t v;
    v.c = c; v.r = r; v.pc = pc; v.push = push; v.pop = pop; v.cack = cack; v.rack = rack;
    v.chk_rpc = chk_rpc; v.rpc = rpc; v.ptr = ptr; v.ptr_after = ptr_after;
    v.full_after = full_after;
    return v;
  endfunction

  logic [4:0] q[$];
  bit         m_cerr, m_rerr;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ptr", 32'(rf_stack_pointer), 0);
    chk("rst_outs", 32'({call_ack, ret_ack, busy, stack_full, rf_stack_push, rf_stack_pop,
                          call_err, ret_err}), 0);
    chk("rst_retpc", 32'(ret_pc), 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed table
    tbl.push_back(mk(1, 0, 5'h04, 1, 0, 1, 0, 0, 5'h00, 5'd1, 5'd1, 0));
    tbl.push_back(mk(0, 1, 5'h00, 0, 1, 0, 1, 1, 5'h05, 5'd1, 5'd0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 0, 5'(i), 1, 0, 1, 0, 0, 5'h00, 5'(i + 1), 5'(i + 1), i == 7));
    tbl.push_back(mk(1, 0, 5'h1F, 0, 0, 1, 0, 0, 5'h00, 5'd8, 5'd8, 1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, 5'h00, 0, 1, 0, 1, 1, 5'(8 - i), 5'(8 - i), 5'(7 - i), 0));
    tbl.push_back(mk(0, 1, 5'h00, 0, 0, 0, 1, 0, 5'h00, 5'd0, 5'd0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      do_op(tbl[i].c, tbl[i].r, tbl[i].pc);
      chk($sformatf("tbl%0d_push", i), 32'(s_push), 32'(tbl[i].push));
      chk($sformatf("tbl%0d_pop", i), 32'(s_pop), 32'(tbl[i].pop));
      chk($sformatf("tbl%0d_cack", i), 32'(s_cack), 32'(tbl[i].cack));
      chk($sformatf("tbl%0d_rack", i), 32'(s_rack), 32'(tbl[i].rack));
      chk($sformatf("tbl%0d_ptr", i), 32'(s_ptr), 32'(tbl[i].ptr));
      chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 1);
      if (tbl[i].chk_rpc) chk($sformatf("tbl%0d_retpc", i), 32'(s_rpc), 32'(tbl[i].rpc));
      chk($sformatf("tbl%0d_ptr_after", i), 32'(s_ptr_a), 32'(tbl[i].ptr_after));
      chk($sformatf("tbl%0d_full_after", i), 32'(s_full_a), 32'(tbl[i].full_after));
      chk($sformatf("tbl%0d_idle_after", i), 32'({s_busy_a, s_ack_a}), 0);
    end
    chk("tbl_call_err", 32'(call_err), 32'(GUARD));
    chk("tbl_ret_err", 32'(ret_err), 32'(GUARD));

    // Simultaneous CALL and RET at pointer 2
    do_reset();
    chk("rst2_errs", 32'({call_err, ret_err}), 0);
    do_op(1, 0, 5'h0A);
    do_op(1, 0, 5'h0B);
    @(negedge clk);
    call_req = 1'b1; ret_req = 1'b1; call_pc = 5'h10;
    @(posedge clk); #1;
    chk("sim_cack", 32'({call_ack, rf_stack_push}), 32'(2'b11));
    chk("sim_no_rack", 32'({ret_ack, rf_stack_pop}), 0);
    chk("sim_ptr_push", 32'(rf_stack_pointer), 3);
    call_req = 1'b0;
    @(posedge clk); #1;
    chk("sim_gap", 32'({busy, ret_ack, call_ack}), 0);
    @(posedge clk); #1;
    chk("sim_rack", 32'({ret_ack, rf_stack_pop}), 32'(2'b11));
    chk("sim_retpc", 32'(ret_pc), 32'h11);
    chk("sim_ptr_pop", 32'(rf_stack_pointer), 3);
    ret_req = 1'b0;
    @(posedge clk); #1;
    chk("sim_ptr_after", 32'(rf_stack_pointer), 2);

    // Reset asserted during PUSH at pointer 3
    @(negedge clk);
    call_req = 1'b1; call_pc = 5'h09;
    @(posedge clk); #1;
    chk("rp_push", 32'(rf_stack_push), 1);
    chk("rp_ptr", 32'(rf_stack_pointer), 3);
    rst_n = 1'b0;
    #1;
    chk("rp_no_ack", 32'({call_ack, rf_stack_push, busy}), 0);
    chk("rp_ptr0", 32'(rf_stack_pointer), 0);
    chk("rp_call_err", 32'(call_err), 0);
    call_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_op(0, 1, 5'h00);
    chk("rp_ret_rej", 32'({s_rack, s_pop}), 32'(2'b10));
    chk("rp_ret_err", 32'(ret_err), 32'(GUARD));

    // Randomized traffic against the reference model
    do_reset();
    q.delete();
    m_cerr = 1'b0; m_rerr = 1'b0;
    for (int n = 0; n < 300; n++) begin
      bit         is_call;
      logic [4:0] pc;
      bit         e_push, e_pop, e_cack, e_rack, chk_rpc;
      logic [4:0] e_rpc, e_ptr, e_after;
      is_call = ($urandom_range(0, 9) < ((n < 150) ? 7 : 3));
      pc = 5'($urandom);
      e_push = 0; e_pop = 0; e_cack = 0; e_rack = 0; chk_rpc = 0; e_rpc = '0;
      if (is_call) begin
        e_cack = 1;
        if (q.size() < DP) begin
          e_push = 1;
          q.push_back(pc + 5'd1);
          e_ptr = 5'(q.size());
        end else begin
          e_ptr = 5'(DP);
          m_cerr = m_cerr | GUARD;
        end
        e_after = e_ptr;
      end else begin
        e_rack = 1;
        if (q.size() > 0) begin
          e_pop = 1; chk_rpc = 1;
          e_ptr = 5'(q.size());
          e_rpc = q.pop_back();
          e_after = 5'(q.size());
        end else begin
          e_ptr = 0; e_after = 0;
          m_rerr = m_rerr | GUARD;
        end
      end
      do_op(is_call, !is_call, pc);
      chk($sformatf("rnd%0d_strobes", n), 32'({s_push, s_pop, s_cack, s_rack}),
          32'({e_push, e_pop, e_cack, e_rack}));
      chk($sformatf("rnd%0d_ptr", n), 32'(s_ptr), 32'(e_ptr));
      if (chk_rpc) chk($sformatf("rnd%0d_retpc", n), 32'(s_rpc), 32'(e_rpc));
      chk($sformatf("rnd%0d_ptr_after", n), 32'(s_ptr_a), 32'(e_after));
      chk($sformatf("rnd%0d_full", n), 32'(s_full_a), 32'(q.size() == DP));
      chk($sformatf("rnd%0d_errs", n), 32'({call_err, ret_err}), 32'({m_cerr, m_rerr}));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
